// File: rtl/clock_burst_scheduler.sv
// clock_burst_scheduler
//
// Shares a stepped simulation clock between several requesters. A round-robin
// arbiter picks one pending request at a time. The winning burst is played out
// as single-cycle Tick pulses that gate the downstream clock-toggle logic.
// Consecutive Ticks are separated by a programmable number of idle cycles.
//
// Ports:
//   Clk        system clock, rising edge
//   Reset      synchronous active-high reset
//   Req        per-requester level request, held until that requester's Done
//   Burst_len  packed burst lengths, requester i at [i*LEN_W +: LEN_W]
//   Rate       idle cycles between Ticks, sampled at grant
//   Halt       freezes an active burst while high
//   Tick       one-cycle clock-enable pulse
//   Grant      one-hot owner of the current burst, zero when idle
//   Busy       high from grant through the Done cycle
//   Done       one-cycle pulse at burst completion
//   Remaining  ticks still to issue in the current burst
module clock_burst_scheduler #(
    parameter int N_REQ  = 4,
    parameter int LEN_W  = 16,
    parameter int RATE_W = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [N_REQ-1:0]       Req,
    input  logic [N_REQ*LEN_W-1:0] Burst_len,
    input  logic [RATE_W-1:0]      Rate,
    input  logic                   Halt,
    output logic                   Tick,
    output logic [N_REQ-1:0]       Grant,
    output logic                   Busy,
    output logic                   Done,
    output logic [LEN_W-1:0]       Remaining
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW    = IDX_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_TICK = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]        state_reg;
    logic [N_REQ-1:0]  grant_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  ptr_reg;
    logic [LEN_W-1:0]  remaining_reg;
    logic [RATE_W-1:0] rate_reg;
    logic [RATE_W-1:0] gap_reg;

    // Unpack the per-requester length fields.
    logic [LEN_W-1:0] len_arr [N_REQ];

    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_len
            assign len_arr[gi] = Burst_len[gi*LEN_W +: LEN_W];
        end
    endgenerate

    // Round-robin search: scan offsets from the highest down so that the
    // smallest offset from the pointer is the last (winning) assignment.
    logic             sel_valid;
    logic [IDX_W-1:0] sel_idx;
    logic [CW-1:0]    cand;

    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr_reg} + CW'(k);
            if (cand >= CW'(N_REQ)) begin
                cand = cand - CW'(N_REQ);
            end
            if (Req[cand[IDX_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[IDX_W-1:0];
            end
        end
    end

    logic [LEN_W-1:0] sel_len;
    assign sel_len = len_arr[sel_idx];

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= S_IDLE;
            grant_reg     <= '0;
            idx_reg       <= '0;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            rate_reg      <= '0;
            gap_reg       <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (sel_valid) begin
                        grant_reg     <= N_REQ'(1) << sel_idx;
                        idx_reg       <= sel_idx;
                        remaining_reg <= sel_len;
                        rate_reg      <= Rate;
                        // A zero-length burst completes without any Tick.
                        state_reg     <= (sel_len != '0) ? S_TICK : S_DONE;
                    end
                end
                S_TICK: begin
                    // A halted Tick is held high but consumed only once, on
                    // the first edge where Halt is low.
                    if (!Halt) begin
                        remaining_reg <= remaining_reg - LEN_W'(1);
                        if (remaining_reg == LEN_W'(1)) begin
                            state_reg <= S_DONE;
                        end else if (rate_reg == '0) begin
                            state_reg <= S_TICK;
                        end else begin
                            state_reg <= S_GAP;
                            gap_reg   <= rate_reg;
                        end
                    end
                end
                S_GAP: begin
                    // Leaving on count 1 yields exactly rate_reg idle cycles.
                    if (!Halt) begin
                        gap_reg <= gap_reg - RATE_W'(1);
                        if (gap_reg == RATE_W'(1)) begin
                            state_reg <= S_TICK;
                        end
                    end
                end
                default: begin
                    // S_DONE: hand priority to the requester after the winner.
                    ptr_reg       <= (idx_reg == IDX_W'(N_REQ - 1)) ? '0 : idx_reg + IDX_W'(1);
                    grant_reg     <= '0;
                    remaining_reg <= '0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign Tick      = (state_reg == S_TICK);
    assign Done      = (state_reg == S_DONE);
    assign Busy      = (state_reg != S_IDLE);
    assign Grant     = grant_reg;
    assign Remaining = remaining_reg;

endmodule

// File: tb/tb_clock_burst_scheduler.sv
// Testbench for clock_burst_scheduler.
// Stimulus issues request rounds; a round-robin reference model predicts the
// sequence of bursts and pushes them into a queue. A monitor on the falling
// edge pops one entry per observed grant and checks the burst's behaviour.
module tb_clock_burst_scheduler;

    localparam int N_REQ  = 4;
    localparam int LEN_W  = 16;
    localparam int RATE_W = 8;

    logic                   Clk;
    logic                   Reset;
    logic [N_REQ-1:0]       Req;
    logic [N_REQ*LEN_W-1:0] Burst_len;
    logic [RATE_W-1:0]      Rate;
    logic                   Halt;
    logic                   Tick;
    logic [N_REQ-1:0]       Grant;
    logic                   Busy;
    logic                   Done;
    logic [LEN_W-1:0]       Remaining;

    clock_burst_scheduler #(
        .N_REQ (N_REQ),
        .LEN_W (LEN_W),
        .RATE_W(RATE_W)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Req      (Req),
        .Burst_len(Burst_len),
        .Rate     (Rate),
        .Halt     (Halt),
        .Tick     (Tick),
        .Grant    (Grant),
        .Busy     (Busy),
        .Done     (Done),
        .Remaining(Remaining)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [N_REQ-1:0] grant;
        int               len;
        int               rate;
        bit               b2b;   // another burst of the same round preceded it
    } burst_t;

    burst_t exp_q[$];
    int     checks    = 0;
    int     failures  = 0;
    int     model_ptr = 0;
    bit     mon_en    = 1'b0;

    task automatic check(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    burst_t cur;
    bit     in_burst = 1'b0;
    int     ticks, gapc, busyc, halts, exp_busy;
    int     idle_cnt = 0;

    always @(negedge Clk) begin
        if (Reset || !mon_en) begin
            in_burst = 1'b0;
            idle_cnt = 0;
        end else begin
            if (Busy && !in_burst) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_grant", Grant, 0);
                end else begin
                    cur      = exp_q.pop_front();
                    in_burst = 1'b1;
                    ticks    = 0;
                    gapc     = 0;
                    busyc    = 0;
                    halts    = 0;
                    check("grant", Grant, cur.grant);
                    check("first_tick", Tick, (cur.len != 0));
                    if (cur.b2b) check("arb_bubble", idle_cnt, 1);
                end
            end
            if (in_burst) begin
                busyc++;
                if (Halt && !Done) halts++;
                if (Tick) begin
                    if (!Halt) begin
                        check("remaining", Remaining, cur.len - ticks);
                        if (ticks > 0) check("tick_gap", gapc, cur.rate);
                        ticks++;
                        gapc = 0;
                    end
                end else if (!Done) begin
                    check("remaining_gap", Remaining, cur.len - ticks);
                    if (!Halt) gapc++;
                end
                if (Done) begin
                    exp_busy = (cur.len == 0) ? 1 : 1 + cur.len + (cur.len - 1) * cur.rate + halts;
                    check("tick_count", ticks, cur.len);
                    check("busy_cycles", busyc, exp_busy);
                    check("done_grant", Grant, cur.grant);
                    check("done_remaining", Remaining, 0);
                    in_burst = 1'b0;
                    idle_cnt = 0;
                end
            end else if (!Busy) begin
                check("idle_outputs", {Tick, Done, Grant, Remaining}, 0);
                idle_cnt++;
            end
        end
    end

    // ---------------- stimulus ----------------
    // halt_mode: 0 none, 1 random, 2 five cycles in the gap after the 2nd tick
    task automatic run_round(input logic [N_REQ-1:0] mask, input int lens[N_REQ],
                             input int rate, input int halt_mode);
        logic [N_REQ-1:0] m;
        int     cyc, hold, seen;
        bit     first, hdone;
        burst_t b;
        m     = mask;
        first = 1'b1;
        while (m != '0) begin
            for (int k = 0; k < N_REQ; k++) begin
                int c;
                c = (model_ptr + k) % N_REQ;
                if (m[c]) begin
                    b.grant = N_REQ'(1) << c;
                    b.len   = lens[c];
                    b.rate  = rate;
                    b.b2b   = !first;
                    exp_q.push_back(b);
                    m[c]      = 1'b0;
                    model_ptr = (c + 1) % N_REQ;
                    first     = 1'b0;
                    break;
                end
            end
        end
        for (int i = 0; i < N_REQ; i++) Burst_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
        Rate  = RATE_W'(rate);
        Halt  = 1'b0;
        Req   = mask;
        cyc   = 0;
        hold  = 0;
        seen  = 0;
        hdone = 1'b0;
        while ((Req != '0 || Busy) && cyc < 4000) begin
            @(posedge Clk);
            #2;
            cyc++;
            if (cyc == 1) check("grant_latency", Busy, 1);
            if (Done) Req = Req & ~Grant;
            if (Busy) begin
                // Inputs that must be ignored once a burst is granted.
                Rate = RATE_W'($urandom);
                for (int i = 0; i < N_REQ; i++)
                    if (Grant[i]) Burst_len[i*LEN_W +: LEN_W] = LEN_W'($urandom);
            end else begin
                Rate = RATE_W'(rate);
            end
            if (halt_mode == 2 && !hdone && seen == 2 && !Tick) begin
                hold  = 5;
                hdone = 1'b1;
            end
            if (halt_mode == 1) Halt = ($urandom_range(99) < 25);
            else Halt = (hold > 0);
            if (hold > 0) hold--;
            if (Tick && !Halt) seen++;
        end
        check("round_done", {Busy, Req}, 0);
        Halt = 1'b0;
        @(posedge Clk);
        #2;
        check("queue_drain", exp_q.size(), 0);
    endtask

    int  lens[N_REQ];
    int  seen_r, cyc_r;
    bit  done_seen;

    initial begin
        Reset     = 1'b1;
        Req       = '0;
        Burst_len = '0;
        Rate      = '0;
        Halt      = 1'b0;
        repeat (3) begin
            @(posedge Clk);
            #2;
            Req  = N_REQ'($urandom);
            Halt = 1'(Req[0]);
            check("reset_outputs", {Tick, Done, Busy, Grant, Remaining}, 0);
        end
        Req   = '0;
        Halt  = 1'b0;
        Reset = 1'b0;
        @(posedge Clk);
        #2;
        mon_en = 1'b1;

        // Round robin with all three held together.
        lens = '{1, 1, 1, 1};
        run_round(4'b0111, lens, 0, 0);
        // Single burst, back-to-back ticks.
        lens = '{3, 0, 0, 0};
        run_round(4'b0001, lens, 0, 0);
        // Rate spacing.
        lens = '{0, 3, 0, 0};
        run_round(4'b0010, lens, 2, 0);
        // Halt during a gap.
        lens = '{4, 0, 0, 0};
        run_round(4'b0001, lens, 1, 2);
        // Zero length, then a full round whose order depends on the pointer.
        lens = '{0, 0, 0, 0};
        run_round(4'b0100, lens, 0, 0);
        lens = '{1, 2, 1, 2};
        run_round(4'b1111, lens, 1, 0);

        // Reset in the middle of a burst.
        mon_en    = 1'b0;
        lens      = '{0, 10, 0, 0};
        for (int i = 0; i < N_REQ; i++) Burst_len[i*LEN_W +: LEN_W] = LEN_W'(lens[i]);
        Rate      = '0;
        Req       = 4'b0010;
        seen_r    = 0;
        cyc_r     = 0;
        done_seen = 1'b0;
        while (seen_r < 4 && cyc_r < 100) begin
            @(posedge Clk);
            #2;
            cyc_r++;
            if (Tick) seen_r++;
            if (Done) done_seen = 1'b1;
        end
        check("pre_reset_ticks", seen_r, 4);
        check("pre_reset_remaining", Remaining, 7);
        Reset = 1'b1;
        @(posedge Clk);
        #2;
        if (Done) done_seen = 1'b1;
        check("abort_tick", Tick, 0);
        check("abort_grant", Grant, 0);
        check("abort_busy", Busy, 0);
        check("abort_remaining", Remaining, 0);
        check("abort_no_done", done_seen, 0);
        Reset     = 1'b0;
        Req       = '0;
        model_ptr = 0;
        @(posedge Clk);
        #2;
        mon_en = 1'b1;
        lens   = '{0, 2, 0, 0};
        run_round(4'b0010, lens, 0, 0);

        // Randomized rounds.
        for (int r = 0; r < 40; r++) begin
            for (int i = 0; i < N_REQ; i++) lens[i] = $urandom_range(0, 6);
            run_round(N_REQ'($urandom_range(1, (1 << N_REQ) - 1)), lens,
                      $urandom_range(0, 3), $urandom_range(0, 1));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

endmodule
